// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write bus of the program loader.
// The slave modport is the loader; master is the stream source and memory side.
interface imem_loader_if;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-memory program loader: 16-bit word count, then little-endian words
// written to consecutive addresses while the CPU fetch stage is held in reset.
//
// state | meaning
// IDLE  | waiting for start, CPU running
// LEN0  | receive low byte of word count
// LEN1  | receive high byte of word count, range check
// DATA  | receive 4*N bytes, one write per completed word
// DONE  | one-cycle completion, last write and done together
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'd0,
    parameter int          MAX_WORDS = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          done,
    output logic          error
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_DONE
    } state_t;

    localparam logic [16:0] MAX_W = 17'(MAX_WORDS);

    state_t      state, state_nx;
    logic        rdy;
    logic        accept;
    logic [7:0]  len_lo;
    logic [15:0] n_words;
    logic [15:0] n_in;
    logic        too_big;
    logic [15:0] word_cnt;
    logic [1:0]  byte_cnt;
    logic [23:0] word_acc;
    logic [31:0] addr;
    logic        last_word;
    logic        wr_en_q;
    logic [31:0] wr_addr_q;
    logic [31:0] wr_data_q;
    logic        error_q;

    assign rdy       = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
    assign accept    = rdy && bus.byte_valid;
    assign n_in      = {bus.byte_data, len_lo};
    assign too_big   = {1'b0, n_in} > MAX_W;
    assign last_word = (word_cnt == n_words - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (start) state_nx = S_LEN0;
            S_LEN0: if (accept) state_nx = S_LEN1;
            S_LEN1: begin
                if (accept) begin
                    if (n_in == 16'd0)  state_nx = S_DONE;
                    else if (too_big)   state_nx = S_IDLE;
                    else                state_nx = S_DATA;
                end
            end
            S_DATA: if (accept && (byte_cnt == 2'd3) && last_word) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo    <= '0;
            n_words   <= '0;
            word_cnt  <= '0;
            byte_cnt  <= '0;
            word_acc  <= '0;
            addr      <= BASE_ADDR;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        error_q  <= 1'b0;
                        byte_cnt <= '0;
                        word_cnt <= '0;
                        addr     <= BASE_ADDR;
                    end
                end
                S_LEN0: if (accept) len_lo <= bus.byte_data;
                S_LEN1: begin
                    if (accept) begin
                        n_words <= n_in;
                        if (too_big) error_q <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        case (byte_cnt)
                            2'd0: word_acc[7:0]   <= bus.byte_data;
                            2'd1: word_acc[15:8]  <= bus.byte_data;
                            2'd2: word_acc[23:16] <= bus.byte_data;
                            default: begin
                                // address wraps silently at 2^32
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= addr;
                                wr_data_q <= {bus.byte_data, word_acc};
                                addr      <= addr + 32'd4;
                                word_cnt  <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.byte_ready = rdy;
    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign cpu_hold       = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign error          = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (base 0x0 and 0x40) share one
// stimulus stream; expected writes are queued as bytes are driven.
module tb_imem_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       bv = 1'b0;
    logic [7:0] bd = 8'd0;
    logic       hold0, done0, err0, hold1, done1, err1;

    always #5 clk = ~clk;

    imem_loader_if if0();
    imem_loader_if if1();
    assign if0.byte_valid = bv;
    assign if0.byte_data  = bd;
    assign if1.byte_valid = bv;
    assign if1.byte_data  = bd;

    imem_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(256)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(if0.slave),
        .cpu_hold(hold0), .done(done0), .error(err0));
    imem_loader #(.BASE_ADDR(32'h0000_0040), .MAX_WORDS(256)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(if1.slave),
        .cpu_hold(hold1), .done(done1), .error(err1));

    typedef struct packed {
        logic [31:0] off;
        logic [31:0] data;
    } wr_t;

    wr_t         q[$];
    int          nchk = 0;
    int          nerr = 0;
    int          dn_cnt = 0;
    int          exp_done = 0;
    logic [31:0] off_next = 0;
    logic [31:0] words[32];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // write/done monitor, sampled on the falling edge
    initial begin
        logic prev_done;
        wr_t  e;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_done = 1'b0;
            end else begin
                if (if0.wr_en) begin
                    if (q.size() == 0) begin
                        chk("wr_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("wr_addr0", if0.wr_addr, e.off);
                        chk("wr_data0", if0.wr_data, e.data);
                        chk("wr_en1", 32'(if1.wr_en), 32'd1);
                        chk("wr_addr1", if1.wr_addr, e.off + 32'h40);
                        chk("wr_data1", if1.wr_data, e.data);
                    end
                end else if (if1.wr_en) begin
                    chk("wr1_unexpected", 32'd1, 32'd0);
                end
                if (done0) begin
                    dn_cnt++;
                    chk("done1", 32'(done1), 32'd1);
                    chk("hold_at_done", 32'(hold0), 32'd1);
                    chk("done_queue_empty", 32'(q.size()), 32'd0);
                    chk("done_single", 32'(prev_done), 32'd0);
                end
                prev_done = done0;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        off_next = 32'd0;
        chk("ready_after_start", 32'(if0.byte_ready), 32'd1);
        chk("hold_after_start", 32'(hold0), 32'd1);
    endtask

    task automatic put_byte(input logic [7:0] b, input int stall);
        int n;
        n = 0;
        repeat (stall) @(negedge clk);
        @(negedge clk);
        bv = 1'b1;
        bd = b;
        while (!if0.byte_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
        chk("hold_busy", 32'(hold0), 32'd1);
        @(posedge clk);
        #1 bv = 1'b0;
    endtask

    task automatic send_words(input int nw, input int stall, input int glitch);
        for (int w = 0; w < nw; w++) begin
            for (int b = 0; b < 4; b++) begin
                if (w * 4 + b == glitch) start = 1'b1;
                if (b == 3) begin
                    q.push_back('{off: off_next, data: words[w]});
                    off_next = off_next + 32'd4;
                end
                put_byte(words[w][8*b +: 8], stall);
                start = 1'b0;
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (dn_cnt < exp_done && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_count", 32'(dn_cnt), 32'(exp_done));
        @(negedge clk);
        chk("hold_released", 32'(hold0), 32'd0);
        chk("ready_idle", 32'(if0.byte_ready), 32'd0);
    endtask

    task automatic session(input logic [15:0] n, input int stall, input int glitch);
        pulse_start();
        put_byte(n[7:0], stall);
        put_byte(n[15:8], stall);
        send_words(int'(n), stall, glitch);
        exp_done++;
        wait_done();
    endtask

    initial begin
        #1;
        chk("rst_ready", 32'(if0.byte_ready), 32'd0);
        chk("rst_wr_en", 32'(if0.wr_en), 32'd0);
        chk("rst_wr_addr", if0.wr_addr, 32'd0);
        chk("rst_wr_data", if0.wr_data, 32'd0);
        chk("rst_hold", 32'(hold0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        chk("rst_error", 32'(err0), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // basic full-rate load
        words[0] = 32'hE3A0_0014;
        words[1] = 32'hE3A0_1A01;
        session(16'd2, 0, -1);

        // same stream with three idle cycles before every byte
        session(16'd2, 3, -1);

        // empty program: done in the cycle after the LEN1 edge
        pulse_start();
        put_byte(8'h00, 0);
        put_byte(8'h00, 0);
        chk("empty_done_now", 32'(done0), 32'd1);
        exp_done++;
        wait_done();

        // oversize length 0x0101 > 256
        pulse_start();
        put_byte(8'h01, 0);
        put_byte(8'h01, 0);
        chk("big_error", 32'(err0), 32'd1);
        chk("big_no_done", 32'(done0), 32'd0);
        chk("big_idle", 32'(hold0), 32'd0);
        repeat (5) @(negedge clk);
        chk("big_error_sticky", 32'(err0), 32'd1);
        chk("big_done_count", 32'(dn_cnt), 32'(exp_done));
        pulse_start();
        chk("error_cleared", 32'(err0), 32'd0);
        put_byte(8'h01, 0);
        put_byte(8'h00, 0);
        words[0] = 32'h1234_5678;
        send_words(1, 0, -1);
        exp_done++;
        wait_done();

        // reset after six data bytes of a three-word load
        words[0] = 32'hA5A5_0001;
        words[1] = 32'h0BAD_F00D;
        pulse_start();
        put_byte(8'h03, 0);
        put_byte(8'h00, 0);
        send_words(1, 0, -1);
        put_byte(8'hEE, 0);
        put_byte(8'hDD, 0);
        @(negedge clk);
        chk("mid_written", 32'(q.size()), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(if0.byte_ready), 32'd0);
        chk("mid_rst_wr_en", 32'(if0.wr_en), 32'd0);
        chk("mid_rst_wr_addr", if0.wr_addr, 32'd0);
        chk("mid_rst_wr_data", if0.wr_data, 32'd0);
        chk("mid_rst_hold", 32'(hold0), 32'd0);
        chk("mid_rst_done", 32'(done0), 32'd0);
        chk("mid_rst_wr_addr1", if1.wr_addr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        words[0] = 32'hCAFE_BEEF;
        session(16'd1, 0, -1);

        // 18 words with a start pulse in the middle of DATA
        for (int i = 0; i < 18; i++) words[i] = $urandom;
        session(16'd18, 0, 21);
        chk("glitch_last_off", off_next, 32'd72);

        // mixed stall pattern
        for (int i = 0; i < 5; i++) words[i] = $urandom;
        session(16'd5, 1, -1);

        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
